dwt_coeff_collector: RTL and testbench

// - Sits directly downstream of the low-pass and high-pass Daubechies-10 convolution pair.
// - Captures one decimated {hi,lo} coefficient pair on every input strobe (the convolutions' parity pulse).
// - Counts pairs up to a programmed frame length and buffers them in a FIFO.
// - The AIRISC core reads pairs out over a valid/ready port; overflow and completion are flagged.

---
 rtl/hss_dwt_pkg.sv | 13 +
 rtl/hss_sync_fifo.sv | 53 +++++
 rtl/dwt_coeff_collector.sv | 132 +++++++++++++
 tb/tb_dwt_coeff_collector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hss_dwt_pkg.sv
// Shared types and constants for the DWT coefficient collector.
package hss_dwt_pkg;

  localparam int DATA_W       = 32;
  localparam int ENERGY_SHIFT = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/hss_sync_fifo.sv
// Synchronous first-word fall-through FIFO. The head is read combinationally
// from the registered array; it reads as zero while the FIFO is empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module hss_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array; left unreset, the empty flag masks stale contents.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dwt_coeff_collector.sv
// Collects decimated {hi,lo} DWT coefficient pairs into a FIFO for one frame.
// Optional detail-energy accumulator enabled by defining DWT_ENERGY_ACC_EN.
//
// state   | meaning
// IDLE    | waiting for start, in_valid ignored
// COLLECT | counting pairs and pushing them to the FIFO
// DONE    | frame complete, FIFO draining, in_valid ignored
module dwt_coeff_collector #(
  parameter int DATA_W = hss_dwt_pkg::DATA_W,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [CNT_W-1:0]    frame_len,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   lo_data,
  input  logic [DATA_W-1:0]   hi_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_W-1:0]    pair_cnt,
  output logic [63:0]         energy
);

  import hss_dwt_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             fifo_full, fifo_empty;
  logic             take, pop, drop;

  // A pending strobe in the same cycle as start belongs to the abandoned frame.
  assign take = (state_q == COLLECT) & in_valid & ~start;
  assign pop  = rd_valid & rd_ready;
  assign drop = take & fifo_full & ~pop;

  hss_sync_fifo #(
    .W     (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (take),
    .din_i   ({hi_data, lo_data}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (rd_data)
  );

  assign rd_valid = ~fifo_empty;
  assign busy     = (state_q == COLLECT);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign pair_cnt = cnt_q;

  // Next state, frame counters and sticky flags.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = COLLECT;
      len_d   = (frame_len == '0) ? CNT_W'(1) : frame_len;
      cnt_d   = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (take) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (drop) ovf_d = 1'b1;
      if (cnt_d == len_q) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DWT_ENERGY_ACC_EN
  logic [63:0] hi_ext, hi_sq, energy_inc, energy_q, energy_d;
  logic [64:0] energy_sum;

  assign hi_ext     = {{(64-DATA_W){hi_data[DATA_W-1]}}, hi_data};
  assign hi_sq      = 64'($signed(hi_ext) * $signed(hi_ext));
  assign energy_inc = hi_sq >> ENERGY_SHIFT;
  assign energy_sum = {1'b0, energy_q} + {1'b0, energy_inc};

  // Saturating accumulate on every counted pair, dropped ones included.
  always_comb begin
    energy_d = energy_q;
    if (start)     energy_d = '0;
    else if (take) energy_d = energy_sum[64] ? '1 : energy_sum[63:0];
  end

  // Energy register.
  always_ff @(posedge CLK) begin
    if (RST) energy_q <= '0;
    else     energy_q <= energy_d;
  end

  assign energy = energy_q;
`else
  assign energy = 64'h0;
`endif

endmodule

// File: tb/tb_dwt_coeff_collector.sv
module tb_dwt_coeff_collector;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] lo_data = '0;
  logic [31:0] hi_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        busy, done, overflow;
  logic [15:0] pair_cnt;
  logic [63:0] energy;

  int vec = 0;
  int err = 0;

  dwt_coeff_collector #(.DATA_W(32), .DEPTH(32), .CNT_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .lo_data   (lo_data),
    .hi_data   (hi_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .pair_cnt  (pair_cnt),
    .energy    (energy)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1;
    frame_len = len;
    tick;
    start = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] lo, input logic [31:0] hi);
    in_valid = 1'b1;
    lo_data = lo;
    hi_data = hi;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic drain(output int n, output logic [63:0] first, output logic [63:0] last);
    n = 0;
    first = '0;
    last = '0;
    rd_ready = 1'b1;
    for (int i = 0; i < 100 && rd_valid; i++) begin
      if (n == 0) first = rd_data;
      last = rd_data;
      n++;
      tick;
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick; tick;
    RST = 1'b0;
    vec++; if (rd_valid !== 1'b0) begin err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    vec++; if (rd_data !== 64'h0) begin err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    vec++; if ({busy, done, overflow} !== 3'b000) begin err++; $display("FAIL reset_flags got %b want 000", {busy, done, overflow}); end
    vec++; if (pair_cnt !== 16'd0) begin err++; $display("FAIL reset_pair_cnt got %0d want 0", pair_cnt); end
    vec++; if (energy !== 64'h0) begin err++; $display("FAIL reset_energy got %h want 0", energy); end
  endtask

  task automatic test_basic;
    logic [31:0] h;
    logic [63:0] exp_d;
    do_start(16'd4);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL basic_busy got %b want 1", busy); end
    rd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      h = 32'(-k);
      exp_d = {h, 32'(k)};
      pulse(32'(k), h);
      vec++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
        err++; $display("FAIL basic_read%0d got %b/%h want 1/%h", k, rd_valid, rd_data, exp_d);
      end
    end
    tick;
    rd_ready = 1'b0;
    vec++; if (rd_valid !== 1'b0) begin err++; $display("FAIL basic_drained got %b want 0", rd_valid); end
    vec++; if ({busy, done, overflow} !== 3'b010) begin err++; $display("FAIL basic_flags got %b want 010", {busy, done, overflow}); end
    vec++; if (pair_cnt !== 16'd4) begin err++; $display("FAIL basic_pair_cnt got %0d want 4", pair_cnt); end
  endtask

  task automatic test_overflow;
    do_start(16'd40);
    for (int k = 1; k <= 40; k++) begin
      if (k == 40) begin
        vec++; if (done !== 1'b0) begin err++; $display("FAIL ovf_early_done got %b want 0", done); end
      end
      pulse(32'(100 + k), 32'(-k));
    end
    vec++; if ({busy, done, overflow} !== 3'b011) begin err++; $display("FAIL ovf_flags got %b want 011", {busy, done, overflow}); end
    vec++; if (pair_cnt !== 16'd40) begin err++; $display("FAIL ovf_pair_cnt got %0d want 40", pair_cnt); end
    vec++; if (rd_data !== {32'hFFFF_FFFF, 32'd101}) begin err++; $display("FAIL ovf_head got %h want ffffffff00000065", rd_data); end
  endtask

  task automatic test_full_push_pop;
    int n;
    logic [63:0] first, last;
    do_start(16'd5);
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL fpp_ovf_clear got %b want 0", overflow); end
    rd_ready = 1'b1;
    pulse(32'd999, 32'd7);
    rd_ready = 1'b0;
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    vec++; if (pair_cnt !== 16'd1) begin err++; $display("FAIL fpp_pair_cnt got %0d want 1", pair_cnt); end
    vec++; if (rd_data !== {32'hFFFF_FFFE, 32'd102}) begin err++; $display("FAIL fpp_head got %h want fffffffe00000066", rd_data); end
    drain(n, first, last);
    vec++; if (n != 32) begin err++; $display("FAIL fpp_count got %0d want 32", n); end
    vec++; if (last !== {32'd7, 32'd999}) begin err++; $display("FAIL fpp_last got %h want 00000007000003e7", last); end
  endtask

  task automatic test_restart;
    int n;
    logic [63:0] first, last;
    do_start(16'd5);
    for (int k = 1; k <= 3; k++) pulse(32'(k), 32'(k));
    start = 1'b1;
    frame_len = 16'd2;
    in_valid = 1'b1;
    lo_data = 32'd55;
    hi_data = 32'd55;
    tick;
    start = 1'b0;
    in_valid = 1'b0;
    vec++; if (pair_cnt !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
      err++; $display("FAIL restart_clear got cnt=%0d done=%b busy=%b want 0/0/1", pair_cnt, done, busy);
    end
    pulse(32'd11, 32'd11);
    vec++; if (done !== 1'b0) begin err++; $display("FAIL restart_mid_done got %b want 0", done); end
    pulse(32'd12, 32'd12);
    vec++; if (done !== 1'b1 || pair_cnt !== 16'd2) begin
      err++; $display("FAIL restart_done got done=%b cnt=%0d want 1/2", done, pair_cnt);
    end
    drain(n, first, last);
    vec++; if (n != 5 || first !== {32'd1, 32'd1} || last !== {32'd12, 32'd12}) begin
      err++; $display("FAIL restart_fifo got n=%0d first=%h last=%h want 5/..1/..c", n, first, last);
    end
  endtask

  task automatic test_zero_len;
    int n;
    logic [63:0] first, last;
    do_start(16'd0);
    pulse(32'd3, 32'd4);
    vec++; if (done !== 1'b1 || pair_cnt !== 16'd1 || busy !== 1'b0) begin
      err++; $display("FAIL zero_len got done=%b cnt=%0d busy=%b want 1/1/0", done, pair_cnt, busy);
    end
    pulse(32'd5, 32'd6);
    vec++; if (pair_cnt !== 16'd1) begin err++; $display("FAIL done_ignores got %0d want 1", pair_cnt); end
    drain(n, first, last);
    vec++; if (n != 1 || first !== {32'd4, 32'd3}) begin
      err++; $display("FAIL zero_len_fifo got n=%0d head=%h want 1/0000000400000003", n, first);
    end
  endtask

  task automatic test_mid_reset;
    do_start(16'd8);
    pulse(32'd1, 32'd2);
    pulse(32'd3, 32'd4);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    vec++; if ({rd_valid, busy, done, overflow} !== 4'b0000 || pair_cnt !== 16'd0 || rd_data !== 64'h0) begin
      err++; $display("FAIL mid_reset got v=%b b=%b d=%b o=%b cnt=%0d want all 0", rd_valid, busy, done, overflow, pair_cnt);
    end
    pulse(32'd9, 32'd9);
    vec++; if (rd_valid !== 1'b0 || pair_cnt !== 16'd0 || busy !== 1'b0) begin
      err++; $display("FAIL idle_ignores got v=%b cnt=%0d busy=%b want 0/0/0", rd_valid, pair_cnt, busy);
    end
  endtask

  task automatic test_energy;
    int n;
    logic [63:0] first, last;
    logic [63:0] exp_e;
`ifdef DWT_ENERGY_ACC_EN
    exp_e = 64'hC000;
`else
    exp_e = 64'h0;
`endif
    do_start(16'd3);
    for (int k = 0; k < 3; k++) pulse(32'd0, 32'h4000);
    vec++; if (energy !== exp_e) begin err++; $display("FAIL energy got %h want %h", energy, exp_e); end
    drain(n, first, last);
    do_start(16'd3);
    vec++; if (energy !== 64'h0) begin err++; $display("FAIL energy_clear got %h want 0", energy); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset;
    test_basic;
    test_overflow;
    test_full_push_pop;
    test_restart;
    test_zero_len;
    test_mid_reset;
    test_energy;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
